// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory slave with configurable wait states,
// byte/half/word loads and stores, and alignment/illegal-code error reporting.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  load_code,
    input  logic [1:0]  store_code,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WLOAD = WAIT_CYCLES > 0 ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           we_q, we_d;
    logic [AW+1:0]  addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [2:0]     lcode_q, lcode_d;
    logic [1:0]     scode_q, scode_d;

    logic [31:0]    mem [DEPTH_WORDS];
    logic [AW-1:0]  idx;
    logic [31:0]    word, ld, wd;
    logic [7:0]     bsel;
    logic [15:0]    hsel;
    logic [3:0]     be;
    logic           err, wr;

    // Upper address bits alias onto the array and are intentionally dropped.
    logic unused_addr;
    assign unused_addr = &{1'b0, addr[31:AW+2]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lcode_d = lcode_q;
        scode_d = scode_q;
        unique case (state_q)
            IDLE: if (req_valid) begin
                state_d = WAIT_CYCLES > 0 ? WAIT : RESP;
                cnt_d   = WLOAD;
                we_d    = req_we;
                addr_d  = addr[AW+1:0];
                wdata_d = wdata;
                lcode_d = load_code;
                scode_d = store_code;
            end
            WAIT: begin
                cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
                state_d = cnt_q == 4'd0 ? RESP : WAIT;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            lcode_q <= '0;
            scode_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lcode_q <= lcode_d;
            scode_q <= scode_d;
        end
    end

    always_comb begin
        idx  = addr_q[AW+1:2];
        word = mem[idx];
        bsel = word[{addr_q[1:0], 3'b000} +: 8];
        hsel = addr_q[1] ? word[31:16] : word[15:0];
        ld   = lcode_q[1:0] == 2'b00 ? {{24{bsel[7] & ~lcode_q[2]}}, bsel} :
               lcode_q[1:0] == 2'b01 ? {{16{hsel[15] & ~lcode_q[2]}}, hsel} : word;
        err  = we_q ? (scode_q == 2'b11 || (scode_q == 2'b01 && addr_q[0]) ||
                       (scode_q == 2'b10 && addr_q[1:0] != 2'b00))
                    : (lcode_q == 3'b011 || lcode_q[2:1] == 2'b11 ||
                       (lcode_q[1:0] == 2'b01 && addr_q[0]) ||
                       (lcode_q == 3'b010 && addr_q[1:0] != 2'b00));
        be   = scode_q == 2'b00 ? 4'b0001 << addr_q[1:0] :
               scode_q == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd   = scode_q == 2'b00 ? {4{wdata_q[7:0]}} :
               scode_q == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
        wr   = state_q == RESP && we_q && !err;
    end

    // Array has no reset; a reset at the RESP edge suppresses the write.
    always_ff @(posedge clk) begin
        if (wr && !rst)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
    end

    assign req_ready  = state_q == IDLE;
    assign resp_valid = state_q == RESP;
    assign resp_err   = resp_valid && err;
    assign rdata      = (resp_valid && !we_q && !err) ? ld : 32'd0;
endmodule
